// File: rtl/control_unit_if.sv
// Control-strobe bundle between the sequencer and the single-bus datapath.
// Zero latency wiring; no backpressure, the datapath obeys every strobe in the cycle it is driven.
interface control_unit_if;
  logic [31:0] ir;
  logic        con_ff;
  logic        stop;
  logic        run;
  logic        PCout, PCin, IncPC;
  logic        MARin, MDRin, MDRout, MDRread, RAMwrite;
  logic        IRin, RYin, RZinLo, RZinHi, RZoutLo, RZoutHi;
  logic        HIin, HIout, LOin, LOout;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, RCout;
  logic        CONin, InPortOut, OutPortIn;

  modport master (
    input  ir, con_ff, stop,
    output run, PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, RAMwrite,
           IRin, RYin, RZinLo, RZinHi, RZoutLo, RZoutHi, HIin, HIout, LOin, LOout,
           Gra, Grb, Grc, Rin, Rout, BAout, RCout, CONin, InPortOut, OutPortIn
  );

  modport slave (
    output ir, con_ff, stop,
    input  run, PCout, PCin, IncPC, MARin, MDRin, MDRout, MDRread, RAMwrite,
           IRin, RYin, RZinLo, RZinHi, RZoutLo, RZoutHi, HIin, HIout, LOin, LOout,
           Gra, Grb, Grc, Rin, Rout, BAout, RCout, CONin, InPortOut, OutPortIn
  );
endinterface

// File: rtl/control_unit.sv
// Hardwired Moore sequencer: fetch F0-F2, execute T3-T7, one state per cycle (memory steps held MEM_WAIT cycles).
// No backpressure input; stop is honoured only at instruction boundaries, halt parks until clear.
module control_unit #(
  parameter int MEM_WAIT = 1
) (
  input logic            clock,
  input logic            clear,
  control_unit_if.master cu
);
  typedef enum logic [3:0] {
    S_RST, S_F0, S_F1, S_F2, S_T3, S_T4, S_T5, S_T6, S_T7, S_STOP, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MULDIV, C_NEGNOT, C_BR,
    C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_HALT, C_NOP
  } iclass_t;

  state_t      state, state_nxt, boundary;
  iclass_t     iclass;
  logic [1:0]  wait_cnt, wait_cnt_nxt;
  logic [2:0]  last_step;
  logic        mem_done;
  logic        unused_ir;

  assign unused_ir = ^cu.ir[26:0];
  assign mem_done  = (wait_cnt == 2'(MEM_WAIT - 1));
  // Every instruction end funnels through here so stop is only seen between instructions.
  assign boundary  = cu.stop ? S_STOP : S_F0;

  always_comb begin
    iclass = C_NOP;
    case (cu.ir[31:27]) inside
      5'd0:            iclass = C_LD;
      5'd1:            iclass = C_LDI;
      5'd2:            iclass = C_ST;
      [5'd3:5'd11]:    iclass = C_ALU;
      [5'd12:5'd14]:   iclass = C_IMM;
      5'd15, 5'd16:    iclass = C_MULDIV;
      5'd17, 5'd18:    iclass = C_NEGNOT;
      5'd19:           iclass = C_BR;
      5'd20:           iclass = C_JR;
      5'd21:           iclass = C_JAL;
      5'd22:           iclass = C_IN;
      5'd23:           iclass = C_OUT;
      5'd24:           iclass = C_MFHI;
      5'd25:           iclass = C_MFLO;
      5'd27:           iclass = C_HALT;
      default:         iclass = C_NOP;
    endcase
  end

  always_comb begin
    case (iclass)
      C_ALU, C_IMM, C_LDI: last_step = 3'd5;
      C_MULDIV, C_BR:      last_step = 3'd6;
      C_NEGNOT, C_JAL:     last_step = 3'd4;
      C_LD, C_ST:          last_step = 3'd7;
      default:             last_step = 3'd3;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state    <= S_RST;
      wait_cnt <= 2'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = 2'd0;
    cu.run = 1'b0;
    cu.PCout = 1'b0;  cu.PCin = 1'b0;    cu.IncPC = 1'b0;
    cu.MARin = 1'b0;  cu.MDRin = 1'b0;   cu.MDRout = 1'b0;  cu.MDRread = 1'b0; cu.RAMwrite = 1'b0;
    cu.IRin = 1'b0;   cu.RYin = 1'b0;    cu.RZinLo = 1'b0;  cu.RZinHi = 1'b0;
    cu.RZoutLo = 1'b0; cu.RZoutHi = 1'b0;
    cu.HIin = 1'b0;   cu.HIout = 1'b0;   cu.LOin = 1'b0;    cu.LOout = 1'b0;
    cu.Gra = 1'b0;    cu.Grb = 1'b0;     cu.Grc = 1'b0;     cu.Rin = 1'b0;     cu.Rout = 1'b0;
    cu.BAout = 1'b0;  cu.RCout = 1'b0;
    cu.CONin = 1'b0;  cu.InPortOut = 1'b0; cu.OutPortIn = 1'b0;

    case (state)
      S_RST:  state_nxt = S_F0;
      S_STOP: if (!cu.stop) state_nxt = S_F0;
      S_HALT: state_nxt = S_HALT;
      S_F0: begin
        cu.run = 1'b1; cu.PCout = 1'b1; cu.MARin = 1'b1; cu.IncPC = 1'b1;
        state_nxt = S_F1;
      end
      S_F1: begin
        cu.run = 1'b1; cu.MDRread = 1'b1; cu.MDRin = 1'b1;
        if (mem_done) state_nxt = S_F2;
        else wait_cnt_nxt = wait_cnt + 2'd1;
      end
      S_F2: begin
        cu.run = 1'b1; cu.MDRout = 1'b1; cu.IRin = 1'b1;
        state_nxt = S_T3;
      end
      S_T3: begin
        cu.run = 1'b1;
        case (iclass)
          C_ALU, C_IMM: begin cu.Grb = 1'b1; cu.Rout = 1'b1; cu.RYin = 1'b1; end
          C_MULDIV:     begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.RYin = 1'b1; end
          C_NEGNOT:     begin cu.Grb = 1'b1; cu.Rout = 1'b1; cu.RZinLo = 1'b1; end
          C_LD, C_LDI, C_ST: begin cu.Grb = 1'b1; cu.BAout = 1'b1; cu.RYin = 1'b1; end
          C_BR:         begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.CONin = 1'b1; end
          C_JR:         begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.PCin = 1'b1; end
          C_JAL:        begin cu.PCout = 1'b1; cu.Grb = 1'b1; cu.Rin = 1'b1; end
          C_IN:         begin cu.InPortOut = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
          C_OUT:        begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.OutPortIn = 1'b1; end
          C_MFHI:       begin cu.HIout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
          C_MFLO:       begin cu.LOout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
          default:      ;
        endcase
        if (iclass == C_HALT)       state_nxt = S_HALT;
        else if (last_step == 3'd3) state_nxt = boundary;
        else                        state_nxt = S_T4;
      end
      S_T4: begin
        cu.run = 1'b1;
        case (iclass)
          C_ALU:        begin cu.Grc = 1'b1; cu.Rout = 1'b1; cu.RZinLo = 1'b1; end
          C_IMM, C_LD, C_LDI, C_ST: begin cu.RCout = 1'b1; cu.RZinLo = 1'b1; end
          C_MULDIV:     begin cu.Grb = 1'b1; cu.Rout = 1'b1; cu.RZinLo = 1'b1; cu.RZinHi = 1'b1; end
          C_NEGNOT:     begin cu.RZoutLo = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
          C_BR:         begin cu.PCout = 1'b1; cu.RYin = 1'b1; end
          C_JAL:        begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.PCin = 1'b1; end
          default:      ;
        endcase
        state_nxt = (last_step == 3'd4) ? boundary : S_T5;
      end
      S_T5: begin
        cu.run = 1'b1;
        case (iclass)
          C_ALU, C_IMM, C_LDI: begin cu.RZoutLo = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
          C_MULDIV:     begin cu.RZoutLo = 1'b1; cu.LOin = 1'b1; end
          C_LD, C_ST:   begin cu.RZoutLo = 1'b1; cu.MARin = 1'b1; end
          C_BR:         begin cu.RCout = 1'b1; cu.RZinLo = 1'b1; end
          default:      ;
        endcase
        state_nxt = (last_step == 3'd5) ? boundary : S_T6;
      end
      S_T6: begin
        cu.run = 1'b1;
        case (iclass)
          C_MULDIV:     begin cu.RZoutHi = 1'b1; cu.HIin = 1'b1; end
          C_LD:         begin cu.MDRread = 1'b1; cu.MDRin = 1'b1; end
          C_ST:         begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.MDRin = 1'b1; end
          // The only Mealy term: branch target is written back only when CON says taken.
          C_BR:         begin cu.RZoutLo = cu.con_ff; cu.PCin = cu.con_ff; end
          default:      ;
        endcase
        if (iclass == C_LD && !mem_done) begin
          wait_cnt_nxt = wait_cnt + 2'd1;
        end else if (last_step == 3'd6) begin
          state_nxt = boundary;
        end else begin
          state_nxt = S_T7;
        end
      end
      S_T7: begin
        cu.run = 1'b1;
        case (iclass)
          C_LD:    begin cu.MDRout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
          C_ST:    cu.RAMwrite = 1'b1;
          default: ;
        endcase
        state_nxt = boundary;
      end
      default: state_nxt = S_RST;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// Runs two sequencers (MEM_WAIT 1 and 2) side by side against a per-instruction strobe-sequence model.
module tb_control_unit;
  localparam logic [28:0] PCOUT   = 29'd1 << 0;
  localparam logic [28:0] PCIN    = 29'd1 << 1;
  localparam logic [28:0] INCPC   = 29'd1 << 2;
  localparam logic [28:0] MARIN   = 29'd1 << 3;
  localparam logic [28:0] MDRIN   = 29'd1 << 4;
  localparam logic [28:0] MDROUT  = 29'd1 << 5;
  localparam logic [28:0] MDRREAD = 29'd1 << 6;
  localparam logic [28:0] RAMWR   = 29'd1 << 7;
  localparam logic [28:0] IRIN    = 29'd1 << 8;
  localparam logic [28:0] RYIN    = 29'd1 << 9;
  localparam logic [28:0] RZINLO  = 29'd1 << 10;
  localparam logic [28:0] RZINHI  = 29'd1 << 11;
  localparam logic [28:0] RZOUTLO = 29'd1 << 12;
  localparam logic [28:0] RZOUTHI = 29'd1 << 13;
  localparam logic [28:0] HIIN    = 29'd1 << 14;
  localparam logic [28:0] HIOUT   = 29'd1 << 15;
  localparam logic [28:0] LOIN    = 29'd1 << 16;
  localparam logic [28:0] LOOUT   = 29'd1 << 17;
  localparam logic [28:0] GRA     = 29'd1 << 18;
  localparam logic [28:0] GRB     = 29'd1 << 19;
  localparam logic [28:0] GRC     = 29'd1 << 20;
  localparam logic [28:0] RIN     = 29'd1 << 21;
  localparam logic [28:0] ROUT    = 29'd1 << 22;
  localparam logic [28:0] BAOUT   = 29'd1 << 23;
  localparam logic [28:0] RCOUT   = 29'd1 << 24;
  localparam logic [28:0] CONIN   = 29'd1 << 25;
  localparam logic [28:0] INPORT  = 29'd1 << 26;
  localparam logic [28:0] OUTPORT = 29'd1 << 27;
  localparam logic [28:0] RUN     = 29'd1 << 28;
  localparam int NDIR = 7;

  logic        clock = 1'b0;
  logic        clear;
  logic        stop;
  logic [31:0] ir_drv  [2];
  logic        con_drv [2];
  logic [28:0] obs     [2];

  always #5 clock = ~clock;

  control_unit_if bus0();
  control_unit_if bus1();

  assign bus0.ir = ir_drv[0];  assign bus0.con_ff = con_drv[0];  assign bus0.stop = stop;
  assign bus1.ir = ir_drv[1];  assign bus1.con_ff = con_drv[1];  assign bus1.stop = stop;

  control_unit #(.MEM_WAIT(1)) dut0 (.clock(clock), .clear(clear), .cu(bus0.master));
  control_unit #(.MEM_WAIT(2)) dut1 (.clock(clock), .clear(clear), .cu(bus1.master));

  assign obs[0] = {bus0.run, bus0.OutPortIn, bus0.InPortOut, bus0.CONin, bus0.RCout, bus0.BAout,
                   bus0.Rout, bus0.Rin, bus0.Grc, bus0.Grb, bus0.Gra, bus0.LOout, bus0.LOin,
                   bus0.HIout, bus0.HIin, bus0.RZoutHi, bus0.RZoutLo, bus0.RZinHi, bus0.RZinLo,
                   bus0.RYin, bus0.IRin, bus0.RAMwrite, bus0.MDRread, bus0.MDRout, bus0.MDRin,
                   bus0.MARin, bus0.IncPC, bus0.PCin, bus0.PCout};
  assign obs[1] = {bus1.run, bus1.OutPortIn, bus1.InPortOut, bus1.CONin, bus1.RCout, bus1.BAout,
                   bus1.Rout, bus1.Rin, bus1.Grc, bus1.Grb, bus1.Gra, bus1.LOout, bus1.LOin,
                   bus1.HIout, bus1.HIin, bus1.RZoutHi, bus1.RZoutLo, bus1.RZinHi, bus1.RZinLo,
                   bus1.RYin, bus1.IRin, bus1.RAMwrite, bus1.MDRread, bus1.MDRout, bus1.MDRin,
                   bus1.MARin, bus1.IncPC, bus1.PCin, bus1.PCout};

  // Reference: each instruction expands to the list of strobe sets it must show, one per cycle.
  logic [28:0] exp_q [2][$];
  logic [28:0] cur     [2];
  logic        in_rst  [2];
  logic        halted  [2];
  logic        pend    [2];
  logic [31:0] pend_ir [2];
  logic        pend_con[2];
  logic [4:0]  cur_op  [2];
  int          dir_idx [2];
  int          mode;
  logic        stop_en;
  logic        found;
  int          n_chk = 0;
  int          n_fail = 0;

  logic [31:0] dir_ir  [NDIR] = '{32'h18A00000, 32'h00880000, 32'h98400000, 32'h98400000,
                                  32'h80A00000, 32'h10C00000, 32'h20600000};
  logic        dir_con [NDIR] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic chk(input string tag, input logic [28:0] got, input logic [28:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  task automatic step(input int k, input logic [28:0] m);
    exp_q[k].push_back(RUN | m);
  endtask

  task automatic start_instr(input int k);
    logic [31:0] nir;
    logic [4:0]  op;
    logic        con;
    int          mw;
    mw = (k == 0) ? 1 : 2;
    if (dir_idx[k] < NDIR) begin
      nir = dir_ir[dir_idx[k]];
      con = dir_con[dir_idx[k]];
      dir_idx[k]++;
    end else begin
      if (mode == 2)      op = 5'd27;
      else if (mode == 3) op = 5'd3;
      else begin
        op = 5'($urandom_range(0, 31));
        if (op == 5'd27) op = 5'd26;
      end
      nir = {op, 27'($urandom)};
      con = 1'($urandom);
    end
    op = nir[31:27];
    pend_ir[k] = nir; pend_con[k] = con; pend[k] = 1'b1; cur_op[k] = op;
    if (op == 5'd27) halted[k] = 1'b1;

    step(k, PCOUT | MARIN | INCPC);
    repeat (mw) step(k, MDRREAD | MDRIN);
    step(k, MDROUT | IRIN);
    if (op <= 5'd2) begin
      step(k, GRB | BAOUT | RYIN);
      step(k, RCOUT | RZINLO);
      if (op == 5'd1) step(k, RZOUTLO | GRA | RIN);
      else            step(k, RZOUTLO | MARIN);
      if (op == 5'd0) begin
        repeat (mw) step(k, MDRREAD | MDRIN);
        step(k, MDROUT | GRA | RIN);
      end else if (op == 5'd2) begin
        step(k, GRA | ROUT | MDRIN);
        step(k, RAMWR);
      end
    end else if (op <= 5'd14) begin
      step(k, GRB | ROUT | RYIN);
      step(k, (op <= 5'd11) ? (GRC | ROUT | RZINLO) : (RCOUT | RZINLO));
      step(k, RZOUTLO | GRA | RIN);
    end else begin
      case (op)
        5'd15, 5'd16: begin
          step(k, GRA | ROUT | RYIN);
          step(k, GRB | ROUT | RZINLO | RZINHI);
          step(k, RZOUTLO | LOIN);
          step(k, RZOUTHI | HIIN);
        end
        5'd17, 5'd18: begin
          step(k, GRB | ROUT | RZINLO);
          step(k, RZOUTLO | GRA | RIN);
        end
        5'd19: begin
          step(k, GRA | ROUT | CONIN);
          step(k, PCOUT | RYIN);
          step(k, RCOUT | RZINLO);
          step(k, con ? (RZOUTLO | PCIN) : 29'd0);
        end
        5'd20: step(k, GRA | ROUT | PCIN);
        5'd21: begin
          step(k, PCOUT | GRB | RIN);
          step(k, GRA | ROUT | PCIN);
        end
        5'd22: step(k, INPORT | GRA | RIN);
        5'd23: step(k, GRA | ROUT | OUTPORT);
        5'd24: step(k, HIOUT | GRA | RIN);
        5'd25: step(k, LOOUT | GRA | RIN);
        default: step(k, 29'd0);
      endcase
    end
    cur[k] = exp_q[k].pop_front();
  endtask

  task automatic advance(input int k);
    if (in_rst[k]) begin
      in_rst[k] = 1'b0;
      start_instr(k);
    end else if (exp_q[k].size() > 0) begin
      cur[k] = exp_q[k].pop_front();
    end else if (halted[k] || stop) begin
      cur[k] = 29'd0;
    end else begin
      start_instr(k);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      exp_q[k].delete();
      cur[k] = 29'd0; in_rst[k] = 1'b1; halted[k] = 1'b0; pend[k] = 1'b0; cur_op[k] = 5'd26;
    end
  endtask

  task automatic cycle_check();
    @(posedge clock);
    @(negedge clock);
    chk("dut0_step", obs[0], cur[0]);
    chk("dut1_step", obs[1], cur[1]);
  endtask

  task automatic cycle_drive();
    stop = stop_en ? ($urandom_range(0, 7) == 0) : 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (pend[k]) begin
        ir_drv[k] = pend_ir[k]; con_drv[k] = pend_con[k]; pend[k] = 1'b0;
      end
      advance(k);
    end
  endtask

  task automatic do_release();
    clear = 1'b1;
    stop  = 1'b0;
    for (int k = 0; k < 2; k++) advance(k);
  endtask

  initial begin
    clear = 1'b0; stop = 1'b0; stop_en = 1'b0; mode = 0; found = 1'b0;
    ir_drv[0] = 32'd0; ir_drv[1] = 32'd0; con_drv[0] = 1'b0; con_drv[1] = 1'b0;
    dir_idx[0] = 0; dir_idx[1] = 0;
    model_reset();
    repeat (2) @(negedge clock);
    chk("reset0", obs[0], 29'd0);
    chk("reset1", obs[1], 29'd0);
    do_release();

    repeat (120) begin cycle_check(); cycle_drive(); end
    mode = 1; stop_en = 1'b1;
    repeat (600) begin cycle_check(); cycle_drive(); end

    // Catch an add in T4 on the MEM_WAIT=1 unit and yank clear mid-instruction.
    mode = 3; stop_en = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      cycle_check();
      if (cur[0] == (RUN | GRC | ROUT | RZINLO) && cur_op[0] == 5'd3) found = 1'b1;
      else cycle_drive();
    end
    chk("reach_add_t4", {28'd0, found}, 29'd1);
    #2 clear = 1'b0;
    #1;
    chk("async_clear0", obs[0], 29'd0);
    chk("async_clear1", obs[1], 29'd0);
    model_reset();
    @(negedge clock);
    chk("held_clear0", obs[0], 29'd0);
    chk("held_clear1", obs[1], 29'd0);
    mode = 1;
    do_release();
    repeat (60) begin cycle_check(); cycle_drive(); end

    mode = 2; stop_en = 1'b1;
    repeat (220) begin cycle_check(); cycle_drive(); end

    #2 clear = 1'b0;
    #1;
    chk("halt_clear0", obs[0], 29'd0);
    chk("halt_clear1", obs[1], 29'd0);
    model_reset();
    @(negedge clock);
    mode = 1; stop_en = 1'b0;
    do_release();
    repeat (40) begin cycle_check(); cycle_drive(); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
